capture_sequencer: RTL



---
 rtl/capture_sequencer_if.sv | 27 ++
 rtl/capture_sequencer.sv | 91 +++++++++
 2 files changed

// File: rtl/capture_sequencer_if.sv
// capture_sequencer_if: trigger, mic-valid and BRAM port-B bundle for capture_sequencer.
// master: PS trigger / pdm_mic side (drives start, abort, num_samples, mic_data_valid).
// slave : capture_sequencer (drives mic_rst, addrb, web, busy, done, sample_count, status).
interface capture_sequencer_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int WEN_WIDTH  = 4
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH:0]   num_samples;
    logic                  mic_data_valid;
    logic                  mic_rst;
    logic [31:0]           addrb;
    logic [WEN_WIDTH-1:0]  web;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH:0]   sample_count;
    logic [31:0]           status;
    modport master (
        output start, abort, num_samples, mic_data_valid,
        input  mic_rst, addrb, web, busy, done, sample_count, status
    );
    modport slave (
        input  start, abort, num_samples, mic_data_valid,
        output mic_rst, addrb, web, busy, done, sample_count, status
    );
endinterface

// File: rtl/capture_sequencer.sv
// capture_sequencer: sequences one PDM capture (settle, then N BRAM writes, then done).
// clk, rst (async, active-high); bus (slave): start/abort/num_samples/mic_data_valid in,
// mic_rst/addrb/web/busy/done/sample_count/status out. status is a plain repacking of registers.
module capture_sequencer #(
    parameter int ADDR_WIDTH     = 14,
    parameter int SETTLE_SAMPLES = 16,
    parameter int WEN_WIDTH      = 4
) (
    input logic                 clk,
    input logic                 rst,
    capture_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;
    localparam int SW = SETTLE_SAMPLES > 0 ? $clog2(SETTLE_SAMPLES + 1) : 1;
    localparam int SL = SETTLE_SAMPLES > 0 ? SETTLE_SAMPLES - 1 : 0;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    state_t              state;
    logic                start_q;
    logic                start_ignored;
    logic                pend;
    logic [SW-1:0]       settle_cnt;
    logic [ADDR_WIDTH:0] n_lat;
    logic                start_rise;
    logic                in_busy;
    assign start_rise = bus.start & ~start_q;
    assign in_busy = state == SETTLE || state == CAPTURE;
    assign bus.status = {bus.busy, bus.done, state, start_ignored,
                         {(26 - ADDR_WIDTH){1'b0}}, bus.sample_count};
    // start_q resets high so a start level held through reset needs a fresh rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            start_q          <= 1'b1;
            start_ignored    <= 1'b0;
            pend             <= 1'b0;
            settle_cnt       <= '0;
            n_lat            <= DEPTH;
            bus.mic_rst      <= 1'b1;
            bus.addrb        <= '0;
            bus.web          <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.sample_count <= '0;
        end else begin
            start_q <= bus.start;
            bus.web <= '0;
            pend    <= 1'b0;
            if (start_rise && in_busy)
                start_ignored <= 1'b1;
            if (bus.abort) begin
                state       <= IDLE;
                bus.mic_rst <= 1'b1;
                bus.busy    <= 1'b0;
                bus.done    <= 1'b0;
            end else if (start_rise && !in_busy) begin
                state            <= SETTLE_SAMPLES == 0 ? CAPTURE : SETTLE;
                n_lat            <= (bus.num_samples == '0 || bus.num_samples > DEPTH) ? DEPTH : bus.num_samples;
                settle_cnt       <= '0;
                start_ignored    <= 1'b0;
                bus.sample_count <= '0;
                bus.mic_rst      <= 1'b0;
                bus.busy         <= 1'b1;
                bus.done         <= 1'b0;
            end else begin
                case (state)
                    SETTLE: if (bus.mic_data_valid) begin
                        settle_cnt <= settle_cnt + 1'b1;
                        if (settle_cnt == SW'(SL))
                            state <= CAPTURE;
                    end
                    CAPTURE: begin
                        // pend delays each valid by one clk so the write lands after mic_data settles.
                        pend <= bus.mic_data_valid;
                        if (pend) begin
                            bus.web          <= '1;
                            bus.addrb        <= 32'({bus.sample_count[ADDR_WIDTH-1:0], 2'b00});
                            bus.sample_count <= bus.sample_count + 1'b1;
                            if (bus.sample_count + 1'b1 == n_lat) begin
                                state       <= DONE;
                                bus.busy    <= 1'b0;
                                bus.done    <= 1'b1;
                                bus.mic_rst <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
